// File: rtl/uart_crc_frame_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_crc_frame_rx_if
//  Description : Serial input and frame/write-strobe outputs of the framed
//                UART receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_crc_frame_rx_if;
    logic        rxd;
    logic        wr_en;
    logic [15:0] wr_adr;
    logic [7:0]  wr_dat;
    logic [7:0]  com;
    logic [7:0]  lbl;
    logic [15:0] crc;
    logic        busy;
    logic        ok_bl;
    logic        err_bl;
    logic [1:0]  err_code;

    // Receiver side: consumes the line, drives the frame outputs.
    modport master (
        input  rxd,
        output wr_en, wr_adr, wr_dat, com, lbl, crc, busy, ok_bl, err_bl, err_code
    );

    modport slave (
        output rxd,
        input  wr_en, wr_adr, wr_dat, com, lbl, crc, busy, ok_bl, err_bl, err_code
    );
endinterface
`default_nettype wire

// File: rtl/uart_crc_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_crc_frame_rx
//  Description : UART byte receiver plus SYNC/COM/ADR/LEN/DATA/CRC-16 frame
//                parser issuing provisional write strobes and a verdict pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_crc_frame_rx #(
    parameter int          CLK_HZ   = 50_000_000,
    parameter int          BAUD     = 115200,
    parameter int          MAX_LEN  = 64,
    parameter logic [7:0]  SYNC     = 8'hA5,
    parameter logic [15:0] CRC_POLY = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'hFFFF,
    parameter int          TMO_BITS = 20
) (
    input wire                  clk,
    input wire                  rst,
    uart_crc_frame_rx_if.master bus
);

    localparam int         c_div     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int         c_half    = c_div / 2;
    localparam int         c_cnt_w   = $clog2(c_div);
    localparam int         c_tmo     = TMO_BITS * c_div;
    localparam int         c_tmo_w   = $clog2(c_tmo + 1);
    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic [2:0] c_st_hunt  = 3'd0;
    localparam logic [2:0] c_st_com   = 3'd1;
    localparam logic [2:0] c_st_adr_h = 3'd2;
    localparam logic [2:0] c_st_adr_l = 3'd3;
    localparam logic [2:0] c_st_len   = 3'd4;
    localparam logic [2:0] c_st_data  = 3'd5;
    localparam logic [2:0] c_st_crc_h = 3'd6;
    localparam logic [2:0] c_st_crc_l = 3'd7;

    // Byte-wise MSB-first CRC: eight shift/XOR steps unrolled.
    function automatic logic [15:0] f_crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] v;
        v = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) begin
            v = v[15] ? ({v[14:0], 1'b0} ^ CRC_POLY) : {v[14:0], 1'b0};
        end
        return v;
    endfunction

    // ------------------------------------------------------------------ sync
    logic r_rxd_meta, r_rxd_sync, r_rxd_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= bus.rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // --------------------------------------------------------- byte receiver
    logic [1:0]         r_rx_state, w_rx_next;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit;
    logic [7:0]         r_rx_shift;
    logic               w_tick, w_half, w_fall;
    logic               w_byte_ok, w_frm_err;
    logic [7:0]         w_byte;

    assign w_tick = (r_rx_cnt == c_cnt_w'(c_div - 1));
    assign w_half = (r_rx_cnt == c_cnt_w'(c_half - 1));
    assign w_fall = r_rxd_prev & ~r_rxd_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= c_rx_idle;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            c_rx_idle:  if (w_fall) w_rx_next = c_rx_start;
            c_rx_start: if (w_half) w_rx_next = r_rxd_sync ? c_rx_idle : c_rx_data;
            c_rx_data:  if (w_tick && r_rx_bit == 3'd7) w_rx_next = c_rx_stop;
            default:    if (w_tick) w_rx_next = c_rx_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_rx_state)
                c_rx_idle: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= 3'd0;
                end
                c_rx_start: r_rx_cnt <= w_half ? '0 : r_rx_cnt + 1'b1;
                c_rx_data: begin
                    r_rx_cnt <= w_tick ? '0 : r_rx_cnt + 1'b1;
                    if (w_tick) begin
                        r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end
                end
                default: r_rx_cnt <= w_tick ? '0 : r_rx_cnt + 1'b1;
            endcase
        end
    end

    assign w_byte_ok = (r_rx_state == c_rx_stop) && w_tick &&  r_rxd_sync;
    assign w_frm_err = (r_rx_state == c_rx_stop) && w_tick && !r_rxd_sync;
    assign w_byte    = r_rx_shift;

    // ------------------------------------------------------------ frame FSM
    logic [2:0]         r_state, w_next;
    logic [7:0]         r_com, r_lbl, r_idx, r_crc_hi;
    logic [15:0]        r_base, r_crc, r_wr_adr;
    logic [7:0]         r_wr_dat;
    logic               r_busy, r_wr_en, r_ok, r_err;
    logic [1:0]         r_err_code;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_tmo, w_in_frame;
    logic               w_wr_en, w_ok, w_err, w_crc_upd;
    logic [1:0]         w_code;

    assign w_in_frame = (r_state != c_st_hunt);
    // A byte completing in the expiry cycle takes precedence.
    assign w_tmo = r_busy && (r_tmo_cnt == c_tmo_w'(c_tmo)) && !w_byte_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_hunt;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_byte_ok) begin
            case (r_state)
                c_st_hunt:  if (w_byte == SYNC) w_next = c_st_com;
                c_st_com:   w_next = c_st_adr_h;
                c_st_adr_h: w_next = c_st_adr_l;
                c_st_adr_l: w_next = c_st_len;
                c_st_len: begin
                    if (w_byte == 8'h00)          w_next = c_st_crc_h;
                    else if (w_byte > c_max_len)  w_next = c_st_hunt;
                    else                          w_next = c_st_data;
                end
                c_st_data:  if (r_idx == r_lbl - 8'd1) w_next = c_st_crc_h;
                c_st_crc_h: w_next = c_st_crc_l;
                default:    w_next = c_st_hunt;
            endcase
        end else if (w_in_frame && (w_frm_err || w_tmo)) begin
            w_next = c_st_hunt;
        end
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_ok      = 1'b0;
        w_err     = 1'b0;
        w_crc_upd = 1'b0;
        w_code    = 2'd0;
        if (w_byte_ok) begin
            case (r_state)
                c_st_com, c_st_adr_h, c_st_adr_l: w_crc_upd = 1'b1;
                c_st_len: begin
                    w_crc_upd = 1'b1;
                    if (w_byte > c_max_len) begin
                        w_err  = 1'b1;
                        w_code = 2'd3;
                    end
                end
                c_st_data: begin
                    w_crc_upd = 1'b1;
                    w_wr_en   = 1'b1;
                end
                c_st_crc_l: begin
                    if ({r_crc_hi, w_byte} == r_crc) w_ok = 1'b1;
                    else                             w_err = 1'b1;
                end
                default: ;
            endcase
        end else if (w_in_frame && w_frm_err) begin
            w_err  = 1'b1;
            w_code = 2'd1;
        end else if (w_in_frame && w_tmo) begin
            w_err  = 1'b1;
            w_code = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_com      <= 8'h00;
            r_lbl      <= 8'h00;
            r_idx      <= 8'h00;
            r_crc_hi   <= 8'h00;
            r_base     <= 16'h0000;
            r_crc      <= CRC_INIT;
            r_wr_adr   <= 16'h0000;
            r_wr_dat   <= 8'h00;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_wr_en <= w_wr_en;
            r_ok    <= w_ok;
            r_err   <= w_err;
            if (w_crc_upd)     r_crc      <= f_crc_upd(r_crc, w_byte);
            if (w_err)         r_err_code <= w_code;
            if (w_ok || w_err) r_busy     <= 1'b0;
            if (w_wr_en) begin
                r_wr_adr <= r_base + {8'h00, r_idx};
                r_wr_dat <= w_byte;
                r_idx    <= r_idx + 8'd1;
            end
            if (w_byte_ok) begin
                case (r_state)
                    c_st_hunt: if (w_byte == SYNC) begin
                        r_crc      <= CRC_INIT;
                        r_busy     <= 1'b1;
                        r_err_code <= 2'd0;
                    end
                    c_st_com:   r_com         <= w_byte;
                    c_st_adr_h: r_base[15:8]  <= w_byte;
                    c_st_adr_l: r_base[7:0]   <= w_byte;
                    c_st_len: begin
                        r_lbl <= w_byte;
                        r_idx <= 8'h00;
                    end
                    c_st_crc_h: r_crc_hi      <= w_byte;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_tmo_cnt <= '0;
        else if (!r_busy || w_byte_ok) r_tmo_cnt <= '0;
        else if (r_tmo_cnt != c_tmo_w'(c_tmo)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_adr   = r_wr_adr;
    assign bus.wr_dat   = r_wr_dat;
    assign bus.com      = r_com;
    assign bus.lbl      = r_lbl;
    assign bus.crc      = r_crc;
    assign bus.busy     = r_busy;
    assign bus.ok_bl    = r_ok;
    assign bus.err_bl   = r_err;
    assign bus.err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_uart_crc_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_crc_frame_rx
//  Description : Directed and randomized frame stimulus for uart_crc_frame_rx
//                checked against a bit-serial CRC / frame reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_crc_frame_rx;
    localparam int CLK_HZ  = 160;
    localparam int BAUD    = 10;
    localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int MAX_LEN = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_crc_frame_rx_if bus ();

    uart_crc_frame_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] wr_log[$];
    int          ok_cnt, err_cnt, viol_cnt;
    logic [1:0]  last_code;
    logic        prev_ok = 1'b0, prev_err = 1'b0, prev_wr = 1'b0;

    logic [7:0]  pay[$];
    logic [7:0]  tx[$];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_crc;

    // Observed-event log plus strobe-shape violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) wr_log.push_back({bus.wr_adr, bus.wr_dat});
            if (bus.ok_bl) ok_cnt++;
            if (bus.err_bl) begin
                err_cnt++;
                last_code = bus.err_code;
            end
            if ((int'(bus.wr_en) + int'(bus.ok_bl) + int'(bus.err_bl)) > 1) viol_cnt++;
            if ((bus.ok_bl || bus.err_bl) && bus.busy) viol_cnt++;
            if ((bus.ok_bl && prev_ok) || (bus.err_bl && prev_err) || (bus.wr_en && prev_wr)) viol_cnt++;
        end
        prev_ok  = bus.ok_bl;
        prev_err = bus.err_bl;
        prev_wr  = bus.wr_en;
    end

    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.rxd = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.rxd = b[k];
            repeat (DIV) @(posedge clk);
        end
        bus.rxd = stop_bit;
        repeat (DIV) @(posedge clk);
        bus.rxd = 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(tx[i], 1'b1);
    endtask

    // Frame bytes, expected writes and expected CRC from the payload queue.
    task automatic build_frame(input logic [7:0] cmd, input logic [15:0] adr, input logic bad);
        logic [7:0]  cov[$];
        logic [15:0] a;
        cov = {cmd, adr[15:8], adr[7:0], 8'(pay.size())};
        foreach (pay[i]) cov.push_back(pay[i]);
        exp_crc = model_crc(cov);
        tx = {8'hA5};
        foreach (cov[i]) tx.push_back(cov[i]);
        tx.push_back(exp_crc[15:8]);
        tx.push_back(exp_crc[7:0] ^ {7'd0, bad});
        exp_wr.delete();
        foreach (pay[i]) begin
            a = adr + 16'(i);
            exp_wr.push_back({a, pay[i]});
        end
    endtask

    task automatic clear_log();
        wr_log.delete();
        ok_cnt   = 0;
        err_cnt  = 0;
        viol_cnt = 0;
    endtask

    task automatic check_frame(input string tag, input int e_ok, input int e_err, input logic [1:0] e_code);
        @(negedge clk);
        chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
        foreach (exp_wr[i]) if (i < wr_log.size()) chk({tag, "_wr"}, wr_log[i], exp_wr[i]);
        chk({tag, "_ok_count"}, ok_cnt, e_ok);
        chk({tag, "_err_count"}, err_cnt, e_err);
        if (e_err > 0) chk({tag, "_err_code"}, last_code, e_code);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_strobe_shape"}, viol_cnt, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic       bad;
        int         len;

        rst     = 1'b1;
        bus.rxd = 1'b1;
        clear_log();
        q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_check_value", model_crc(q), 16'h29B1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_ok", bus.ok_bl, 1'b0);
        chk("rst_err", bus.err_bl, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_adr_dat", {bus.wr_adr, bus.wr_dat}, 24'h0);
        chk("rst_com_lbl_code", {bus.com, bus.lbl, 6'd0, bus.err_code}, 24'h0);
        chk("rst_crc", bus.crc, 16'hFFFF);
        rst = 1'b0;
        repeat (2 * DIV) @(posedge clk);

        // Good frame
        pay = {8'h11, 8'h22, 8'h33};
        build_frame(8'h01, 16'h0010, 1'b0);
        clear_log();
        send_range(0, tx.size() - 1);
        check_frame("good", 1, 0, 2'd0);
        chk("good_com", bus.com, 8'h01);
        chk("good_lbl", bus.lbl, 8'h03);
        chk("good_crc", bus.crc, exp_crc);

        // CRC error
        build_frame(8'h01, 16'h0010, 1'b1);
        clear_log();
        send_range(0, tx.size() - 1);
        check_frame("crcerr", 0, 1, 2'd0);

        // Length over limit
        tx = {8'hA5, 8'h02, 8'h00, 8'h00, 8'(MAX_LEN + 1)};
        exp_wr.delete();
        clear_log();
        send_range(0, tx.size() - 1);
        repeat (DIV) @(posedge clk);
        check_frame("overlen", 0, 1, 2'd3);
        chk("overlen_lbl", bus.lbl, 8'h41);

        // Zero length
        pay.delete();
        build_frame(8'h07, 16'h1234, 1'b0);
        clear_log();
        send_range(0, tx.size() - 1);
        check_frame("zerolen", 1, 0, 2'd0);

        // Timeout after second payload byte, then recovery
        pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build_frame(8'h03, 16'h0100, 1'b0);
        clear_log();
        send_range(0, 6);
        repeat (21 * DIV) @(posedge clk);
        while (exp_wr.size() > 2) void'(exp_wr.pop_back());
        check_frame("timeout", 0, 1, 2'd2);
        pay = {8'(($urandom)), 8'(($urandom)), 8'(($urandom))};
        build_frame(8'h04, 16'h2000, 1'b0);
        clear_log();
        send_range(0, tx.size() - 1);
        check_frame("recover", 1, 0, 2'd0);

        // Address wrap
        pay = {8'h5A, 8'hC3};
        build_frame(8'h08, 16'hFFFF, 1'b0);
        clear_log();
        send_range(0, tx.size() - 1);
        check_frame("wrap", 1, 0, 2'd0);
        if (wr_log.size() == 2) begin
            chk("wrap_adr0", wr_log[0][23:8], 16'hFFFF);
            chk("wrap_adr1", wr_log[1][23:8], 16'h0000);
        end

        // Stop-bit error mid-frame
        pay = {8'h10, 8'h20, 8'h30};
        build_frame(8'h05, 16'h0020, 1'b0);
        clear_log();
        send_range(0, 5);
        send_byte(8'h20, 1'b0);
        repeat (2 * DIV) @(posedge clk);
        while (exp_wr.size() > 1) void'(exp_wr.pop_back());
        check_frame("stoperr", 0, 1, 2'd1);

        // Short glitch inside a frame must not produce a byte
        pay = {8'h01, 8'h02};
        build_frame(8'h09, 16'h0300, 1'b0);
        clear_log();
        send_range(0, 1);
        repeat (DIV) @(posedge clk);
        bus.rxd = 1'b0;
        repeat (DIV / 4) @(posedge clk);
        bus.rxd = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        send_range(2, tx.size() - 1);
        check_frame("glitch", 1, 0, 2'd0);

        // Reset during DATA
        pay = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        build_frame(8'h06, 16'h0040, 1'b0);
        clear_log();
        send_range(0, 6);
        @(negedge clk);
        chk("rstmid_busy_before", bus.busy, 1'b1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_wr_en", bus.wr_en, 1'b0);
        chk("rstmid_crc", bus.crc, 16'hFFFF);
        chk("rstmid_com", bus.com, 8'h00);
        rst = 1'b0;
        clear_log();
        repeat (3 * DIV) @(posedge clk);
        chk("rstmid_no_wr", wr_log.size(), 0);
        pay = {8'h71, 8'h72};
        build_frame(8'h0A, 16'h0500, 1'b0);
        clear_log();
        send_range(0, tx.size() - 1);
        check_frame("after_rst", 1, 0, 2'd0);

        // Randomized frames, gaps of zero or one bit period
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(0, 6));
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            bad = ($urandom_range(0, 3) == 0);
            build_frame(8'($urandom), 16'($urandom), bad);
            clear_log();
            send_range(0, tx.size() - 1);
            check_frame("rand", bad ? 0 : 1, bad ? 1 : 0, 2'd0);
            chk("rand_com_lbl", {bus.com, bus.lbl}, {tx[1], tx[4]});
            chk("rand_crc", bus.crc, exp_crc);
            repeat (int'($urandom_range(0, 1)) * DIV) @(posedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_crc_frame_rx.md
# uart_crc_frame_rx

Parametrised UART framed-block receiver with CRC-16 check. It deserialises bytes from `rxd`, hunts for a sync byte, and parses a command/address/length/payload/CRC frame. Payload writes are issued as address/data strobes, and each frame ends with a single pass or fail pulse. It is the next-generation receive front end feeding the register/memory block and the reply transmitter. Compared with the fixed version it adds configurable baud, payload limit, polynomial, inter-byte timeout and error classification.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate. `DIV = (CLK_HZ + BAUD/2) / BAUD` cycles per bit.
- `MAX_LEN`, 64, maximum payload bytes (1..255).
- `SYNC`, 8'hA5, frame start byte.
- `CRC_POLY`, 16'h1021, CRC generator polynomial.
- `CRC_INIT`, 16'hFFFF, CRC preset.
- `TMO_BITS`, 20, inter-byte timeout in bit periods.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rxd` in 1: serial input, idle high, asynchronous to `clk`.
- `wr_en` out 1: one-cycle strobe per payload byte.
- `wr_adr` out 16: payload byte address.
- `wr_dat` out 8: payload byte.
- `com` out 8: command byte of the current or last frame.
- `lbl` out 8: length byte of the current or last frame.
- `crc` out 16: running computed CRC.
- `busy` out 1: frame in progress.
- `ok_bl` out 1: one-cycle pulse, frame CRC correct.
- `err_bl` out 1: one-cycle pulse, frame aborted or rejected.
- `err_code` out 2: 0 = CRC mismatch, 1 = stop-bit error, 2 = timeout, 3 = length > `MAX_LEN`.

## Operation
- **Input synchronisation.** `rxd` passes through a 2-FF synchroniser. All logic uses the synchronised value.
- **Byte receiver.**
  - IDLE: a falling edge starts a counter.
  - At `DIV/2` the line is re-sampled. If it is high, this is a false start and the receiver returns to IDLE.
  - Otherwise 8 data bits are sampled LSB-first at `DIV` intervals, then the stop bit.
  - Stop = 1 produces a `byte_ok` pulse. Stop = 0 produces a `frm_err` pulse.
- **Frame FSM states:** HUNT, COM, ADR_H, ADR_L, LEN, DATA, CRC_H, CRC_L.
  - HUNT: non-SYNC bytes and `frm_err` are ignored. On SYNC: `crc <= CRC_INIT`, `busy <= 1`, `err_code <= 0`, go to COM.
  - COM: latch `com`.
  - ADR_H / ADR_L: latch the base address, MSB first.
  - LEN: latch `lbl`.
    - `lbl == 0` → CRC_H.
    - `lbl > MAX_LEN` → `err_bl`, code 3, HUNT.
    - Otherwise → DATA with index = 0.
  - DATA: each byte drives `wr_en = 1`, `wr_dat = byte`, `wr_adr = base + index` (mod 2^16, wraps FFFF→0000), then index++. After `lbl` bytes go to CRC_H.
  - CRC_H / CRC_L: receive the CRC, MSB first.
    - Match with `crc` → `ok_bl`.
    - Mismatch → `err_bl`, code 0.
    - Either way return to HUNT and clear `busy`.
- **CRC.**
  - Covers COM, ADR_H, ADR_L, LEN and DATA. SYNC and CRC bytes are excluded.
  - Algorithm: MSB-first, non-reflected, no final XOR. With defaults this is CRC-16/CCITT-FALSE; the check value for ASCII "123456789" is 16'h29B1.
  - Update is byte-wise: 8 shift/XOR steps unrolled into one cycle.
- **Errors while `busy`.**
  - `frm_err` → `err_bl`, code 1, HUNT.
  - Timeout counter exceeds `TMO_BITS*DIV` cycles since the last byte end → `err_bl`, code 2, HUNT.
- **Provisional writes.** `wr_en` writes are issued before the CRC verdict. Consumers commit only on `ok_bl`.
- **Output holding.** `err_code`, `com` and `lbl` hold until the next SYNC.

## Timing
- **Reset values:** `wr_en`, `ok_bl`, `err_bl`, `busy` = 0; `wr_adr`, `wr_dat`, `com`, `lbl`, `err_code` = 0; `crc = CRC_INIT`. FSM in HUNT, byte receiver in IDLE.
- **`rst` mid-frame:** everything returns to reset values immediately. No strobes follow.
- **Input latency:** 2 cycles through the synchroniser. The stop-bit sample occurs 9.5 bit periods after the start edge.
- **`byte_ok` to outputs:** `wr_en`, `ok_bl` and `err_bl` assert exactly 1 cycle after `byte_ok`. `crc` is updated in the same cycle.
- **Strobe widths:** `wr_en`, `ok_bl` and `err_bl` are exactly 1 cycle wide and mutually exclusive. `busy` falls in the same cycle as `ok_bl`/`err_bl`.
- **Timeout counter:** cleared by `byte_ok`. If `byte_ok` and timeout expiry coincide, the byte wins.
- **Back-to-back:** the receiver accepts a new start edge in the cycle after the stop sample, so zero-gap frames are supported.

## Test plan
- **Good frame:** A5 01 00 10 03 11 22 33 + CRC from the bench model → `wr_en` ×3 with (`wr_adr`, `wr_dat`) = (0010,11), (0011,22), (0012,33); one `ok_bl`; `com` = 01, `lbl` = 03, `busy` low afterwards.
- **CRC error:** same frame with the final CRC byte XOR 01 → three `wr_en`, then `err_bl` with `err_code` = 0 and no `ok_bl`.
- **Length and zero-length:**
  - LEN = `MAX_LEN`+1 (0x41) → `err_bl`, code 3, no `wr_en`.
  - Frame with LEN = 0 and correct CRC → `ok_bl`, no `wr_en`.
- **Timeout and recovery:** idle 21 bit periods after the 2nd payload byte → `err_bl`, code 2. An immediately following good frame → `ok_bl`.
- **Wrap and stop-bit error:**
  - Address FFFF, LEN 2 → `wr_adr` FFFF then 0000.
  - A byte with stop = 0 mid-frame → `err_bl`, code 1.
- **Glitch and reset:**
  - Low pulse of `DIV/4` on idle `rxd` → no byte.
  - `rst` asserted during DATA → `busy` = 0, no further `wr_en`, and the next frame is received normally.
